// File: rtl/ram_2port_be_if.sv
// Bus bundle for ram_2port_be: write port, read port and clear/busy control.
// The RAM takes the slave modport; the user logic takes master.
interface ram_2port_be_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = WIDTH / 8;

  logic             i_Wr_DV;
  logic [AW-1:0]    i_Wr_Addr;
  logic [WIDTH-1:0] i_Wr_Data;
  logic [NB-1:0]    i_Wr_BE;
  logic             i_Rd_En;
  logic [AW-1:0]    i_Rd_Addr;
  logic [WIDTH-1:0] o_Rd_Data;
  logic             o_Rd_DV;
  logic             i_Clear;
  logic             o_Busy;

  modport slave (
    input  i_Wr_DV, i_Wr_Addr, i_Wr_Data, i_Wr_BE, i_Rd_En, i_Rd_Addr, i_Clear,
    output o_Rd_Data, o_Rd_DV, o_Busy
  );

  modport master (
    output i_Wr_DV, i_Wr_Addr, i_Wr_Data, i_Wr_BE, i_Rd_En, i_Rd_Addr, i_Clear,
    input  o_Rd_Data, o_Rd_DV, o_Busy
  );
endinterface

// File: rtl/ram_2port_be.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read latency, selectable
// read-during-write behaviour and a zeroing clear engine.
module ram_2port_be #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  ram_2port_be_if.slave      ram_io
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = WIDTH / 8;
  localparam logic [AW:0]   DepthW   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;
  localparam state_e StReset = (CLEAR_ON_RESET != 0) ? StClear : StIdle;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             busy;
  logic             wr_in_range, rd_in_range;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] wr_old, wr_merged, rd_word;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic             dv1_q, dv1_d, dv2_q, dv2_d;
  logic [WIDTH-1:0] data1_q, data1_d, data2_q, data2_d;

  assign busy        = (state_q == StClear);
  assign wr_in_range = ({1'b0, ram_io.i_Wr_Addr} < DepthW);
  assign rd_in_range = ({1'b0, ram_io.i_Rd_Addr} < DepthW);
  assign wr_acc      = ram_io.i_Wr_DV & ~busy & wr_in_range;
  assign rd_acc      = ram_io.i_Rd_En & ~busy;

  // Byte-merged write word; also serves as the write-first bypass value.
  always_comb begin
    wr_old    = wr_in_range ? mem_q[ram_io.i_Wr_Addr] : '0;
    wr_merged = wr_old;
    for (int k = 0; k < NB; k++) begin
      if (ram_io.i_Wr_BE[k]) wr_merged[8*k +: 8] = ram_io.i_Wr_Data[8*k +: 8];
    end
  end

  always_comb begin
    if (!rd_in_range) begin
      rd_word = '0;
    end else if ((RDW_MODE == 1) && wr_acc && (ram_io.i_Wr_Addr == ram_io.i_Rd_Addr)) begin
      rd_word = wr_merged;
    end else begin
      rd_word = mem_q[ram_io.i_Rd_Addr];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = ram_io.i_Wr_Addr;
    mem_wdata = wr_merged;
    unique case (state_q)
      StIdle: begin
        mem_we = wr_acc;
        if (ram_io.i_Clear) state_d = StClear;
      end
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stage 2 drains independently of busy so in-flight reads still complete.
  always_comb begin
    dv1_d   = rd_acc;
    data1_d = rd_acc ? rd_word : data1_q;
    dv2_d   = dv1_q;
    data2_d = dv1_q ? data1_q : data2_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= StReset;
      cnt_q   <= '0;
      dv1_q   <= 1'b0;
      dv2_q   <= 1'b0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dv1_q   <= dv1_d;
      dv2_q   <= dv2_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign ram_io.o_Rd_DV   = (RD_LATENCY == 2) ? dv2_q : dv1_q;
  assign ram_io.o_Rd_Data = (RD_LATENCY == 2) ? data2_q : data1_q;
  assign ram_io.o_Busy    = busy;
endmodule

// File: doc/ram_2port_be.md
Name: ram_2port_be

Overview:
- Parametrised simple dual-port RAM: one write port and one read port on a single clock.
- Next generation of the team's single-port RAM. Adds per-byte write enables, selectable read latency (1 or 2), selectable read-during-write behaviour, and a hardware clear engine that zeroes the array after reset or on request.
- Used as the storage primitive under FIFOs and buffers in the memory library.

Parameters:
- WIDTH, 16, data width in bits; must be a multiple of 8; NB = WIDTH/8 byte lanes.
- DEPTH, 8, number of words; any value >= 2, need not be a power of two.
- RD_LATENCY, 1, read latency in clocks; legal values 1 or 2.
- RDW_MODE, 0, same-address read during write: 0 = old data, 1 = new data (write-first bypass, byte-merged).
- CLEAR_ON_RESET, 1, 1 = run the clear engine automatically after reset deassertion.

Ports:
- i_Clk  in  1  clock; all logic on the rising edge.
- i_Rst_L  in  1  reset, asynchronous assert, active-low.
- i_Wr_DV  in  1  write strobe.
- i_Wr_Addr  in  AW  write address; AW = $clog2(DEPTH).
- i_Wr_Data  in  WIDTH  write data.
- i_Wr_BE  in  NB  byte enables; bit k gates bits [8k+7:8k].
- i_Rd_En  in  1  read request.
- i_Rd_Addr  in  AW  read address.
- o_Rd_Data  out  WIDTH  read data.
- o_Rd_DV  out  1  read data valid, one-cycle pulse per accepted read.
- i_Clear  in  1  request a clear of the whole array.
- o_Busy  out  1  clear engine active; user writes and reads are ignored while high.

Behaviour:
- Reset (i_Rst_L low), asynchronous:
  - o_Rd_Data = 0, o_Rd_DV = 0, read pipeline valid bits = 0, clear counter = 0.
  - FSM = CLEAR if CLEAR_ON_RESET = 1, else IDLE. o_Busy follows the FSM state.
  - The memory array itself has no reset.
- FSM states:
  - IDLE: i_Clear high -> CLEAR on the next edge.
  - CLEAR: each cycle, write all-zero to address cnt, then cnt++. After writing DEPTH-1 -> IDLE. o_Busy is high for exactly DEPTH cycles.
  - i_Clear is ignored while in CLEAR; it does not restart the sweep.
- Reset during CLEAR: the sweep aborts. After deassertion it restarts from address 0 if CLEAR_ON_RESET = 1; otherwise the FSM enters IDLE and array contents are undefined.
- Write, with o_Busy low: on an edge where i_Wr_DV = 1, for each k with i_Wr_BE[k] = 1, mem[i_Wr_Addr] lane k <= i_Wr_Data lane k. Other lanes are unchanged. BE = 0 is a no-op.
- Read, with o_Busy low: i_Rd_En sampled high at edge N.
  - RD_LATENCY = 1: o_Rd_Data and o_Rd_DV = 1 are updated at edge N and held for one cycle.
  - RD_LATENCY = 2: data is registered again and presented at edge N+1.
  - Back-to-back reads give one result per cycle. o_Rd_DV is high for exactly one cycle per accepted read.
  - o_Rd_Data holds its last value while o_Rd_DV = 0.
- Same-address read and write in the same cycle:
  - RDW_MODE = 0: returns the pre-write word.
  - RDW_MODE = 1: returns the merged word; enabled lanes come from i_Wr_Data, disabled lanes from the old word.
- Out-of-range address (>= DEPTH, possible only when DEPTH is not a power of two):
  - Write: ignored.
  - Read: still accepted; o_Rd_DV pulses with o_Rd_Data = 0.
- While o_Busy = 1:
  - i_Wr_DV and i_Rd_En are ignored; no o_Rd_DV is generated.
  - Reads accepted before the clear started still drain from the pipeline normally.

Test Plan:
- DEPTH=8, CLEAR_ON_RESET=1, after a dirty fill: release reset -> o_Busy high for exactly 8 cycles; then reading addresses 0..7 returns 0x0000 with 8 o_Rd_DV pulses.
- Byte enables: write 0xABCD BE=2'b11 to addr 3, then 0x0012 BE=2'b01 to addr 3 -> read addr 3 returns 0xAB12; BE=2'b00 write of 0xFFFF leaves 0xAB12.
- Latency: burst-read addresses 0..3 holding 0x0001..0x0004. RD_LATENCY=1 -> DV starts 1 edge after the first request; RD_LATENCY=2 -> 2 edges after. 4 contiguous pulses, data in order.
- Read during write: addr 2 holds 0x1111; same-edge write 0x5555 BE=2'b01 and read addr 2. RDW_MODE=0 -> 0x1111; RDW_MODE=1 -> 0x1155; a subsequent read returns 0x1155 in both modes.
- Clear and reset interaction:
  - Pulse i_Clear -> o_Busy for DEPTH cycles; a second i_Clear mid-sweep does not extend it; writes issued during busy are lost.
  - Assert reset at sweep cycle 3 -> outputs 0 immediately; after release a full 8-cycle sweep follows.
- DEPTH=6, AW=3: write 0x7777 to addr 6 -> no effect; read addr 7 -> DV pulse with 0x0000; addr 5 reads and writes correctly.
